// File: rtl/fifo1_enq_arbiter_if.sv
// Enq handshake bundle between NREQ requesters, the arbiter and a one-element FIFO.
//   slave  : arbiter side (takes requests, drives RDY and the FIFO enq port)
//   master : environment side (drives requests and FIFO readiness)
// Signals:
//   req__VALID/req__ENA [NREQ]  : per-requester has-data / fire
//   req_v [NREQ*DATA_WIDTH]     : per-requester payload, slice i at i*DATA_WIDTH
//   req__RDY [NREQ]             : per-requester may-fire (one-hot or zero)
//   out_enq__RDY                : FIFO not full
//   out_enq__ENA/out_enq_v      : enq fire and payload toward the FIFO
//   out_tag [TAG_W]             : index of the granted requester
interface fifo1_enq_arbiter_if #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned TAG_W      = 2,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [NREQ-1:0]            req__VALID;
  logic [NREQ-1:0]            req__ENA;
  logic [NREQ*DATA_WIDTH-1:0] req_v;
  logic [NREQ-1:0]            req__RDY;
  logic                       out_enq__RDY;
  logic                       out_enq__ENA;
  logic [DATA_WIDTH-1:0]      out_enq_v;
  logic [TAG_W-1:0]           out_tag;

  modport slave (
    input  req__VALID, req__ENA, req_v, out_enq__RDY,
    output req__RDY, out_enq__ENA, out_enq_v, out_tag
  );

  modport master (
    output req__VALID, req__ENA, req_v, out_enq__RDY,
    input  req__RDY, out_enq__ENA, out_enq_v, out_tag
  );
endinterface

// File: rtl/fifo1_enq_arbiter.sv
// Round-robin arbiter sharing one FIFO enq method between NREQ requesters,
// with optional burst lock, saturating per-requester grant counters and a
// sticky protocol-error flag.
// Ports:
//   CLK, nRST    : clock, synchronous active-low reset
//   bus          : request/enq handshake bundle (slave side)
//   stat_clear   : clear all grant counters on the next edge
//   stat_sel     : counter selector for stat_count
//   stat_count   : registered grant count of requester stat_sel (0 if out of range)
//   proto_err    : sticky, set when an ENA arrives without its RDY
module fifo1_enq_arbiter #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned TAG_W      = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST      = 1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 CLK,
  input  logic                 nRST,
  fifo1_enq_arbiter_if.slave   bus,
  input  logic                 stat_clear,
  input  logic [TAG_W-1:0]     stat_sel,
  output logic [CNT_WIDTH-1:0] stat_count,
  output logic                 proto_err
);

  localparam int unsigned BCNT_W = (BURST < 2) ? 1 : $clog2(BURST + 1);
  localparam int unsigned SUM_W  = TAG_W + 1;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [TAG_W-1:0]     r_ptr;
  logic [TAG_W-1:0]     w_ptr_nxt;
  logic [TAG_W-1:0]     r_owner;
  logic [TAG_W-1:0]     w_owner_nxt;
  logic [BCNT_W-1:0]    r_bcnt;
  logic [BCNT_W-1:0]    w_bcnt_nxt;
  logic [CNT_WIDTH-1:0] r_cnt [NREQ];
  logic [CNT_WIDTH-1:0] r_stat_count;
  logic                 r_proto_err;

  logic [TAG_W-1:0]     w_grant;
  logic [SUM_W-1:0]     w_sum;
  logic [NREQ-1:0]      w_rdy;
  logic                 w_any_valid;
  logic                 w_hold_eff;
  logic                 w_xfer;
  logic                 w_err;

  // Burst lock only applies while the owner still has data.
  assign w_hold_eff  = (r_state == HOLD) && bus.req__VALID[r_owner];
  assign w_any_valid = |bus.req__VALID;

  // Grant select: owner during a live burst, otherwise first VALID from ptr.
  // Scanning downward lets the lowest offset from ptr win without a found flag.
  always_comb begin
    w_grant = '0;
    w_sum   = '0;
    if (w_hold_eff) begin
      w_grant = r_owner;
    end else begin
      for (int k = int'(NREQ) - 1; k >= 0; k--) begin
        w_sum = {1'b0, r_ptr} + SUM_W'(k);
        if (w_sum >= SUM_W'(NREQ)) begin
          w_sum = w_sum - SUM_W'(NREQ);
        end
        if (bus.req__VALID[w_sum[TAG_W-1:0]]) begin
          w_grant = w_sum[TAG_W-1:0];
        end
      end
    end
  end

  // Handshake: RDY is one-hot on the grant and never looks at ENA.
  always_comb begin
    w_rdy = '0;
    if (nRST && bus.out_enq__RDY && w_any_valid) begin
      w_rdy[w_grant] = 1'b1;
    end
  end

  assign w_xfer = |(bus.req__ENA & w_rdy);
  assign w_err  = |(bus.req__ENA & ~w_rdy);

  assign bus.req__RDY    = w_rdy;
  assign bus.out_enq__ENA = w_xfer;
  assign bus.out_tag     = nRST ? w_grant : '0;
  assign bus.out_enq_v   = nRST ? bus.req_v[32'(w_grant) * DATA_WIDTH +: DATA_WIDTH] : '0;

  // Arbitration state register.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= ARB;
      r_ptr   <= '0;
      r_owner <= '0;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_bcnt  <= w_bcnt_nxt;
    end
  end

  // Next-state: everything freezes while the FIFO is full.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_bcnt_nxt  = r_bcnt;
    if (bus.out_enq__RDY) begin
      // Owner ran dry: release the lock; this cycle's grant is already round-robin.
      if ((r_state == HOLD) && !w_hold_eff) begin
        w_state_nxt = ARB;
        w_bcnt_nxt  = '0;
      end
      if (w_xfer) begin
        w_ptr_nxt = (w_grant == TAG_W'(NREQ - 1)) ? '0 : w_grant + TAG_W'(1);
        if (w_hold_eff) begin
          if (r_bcnt == BCNT_W'(BURST - 1)) begin
            w_state_nxt = ARB;
            w_bcnt_nxt  = '0;
          end else begin
            w_bcnt_nxt = r_bcnt + BCNT_W'(1);
          end
        end else if (BURST > 1) begin
          w_state_nxt = HOLD;
          w_owner_nxt = w_grant;
          w_bcnt_nxt  = BCNT_W'(1);
        end
      end
    end
  end

  // Grant counters: clear beats a same-cycle transfer; increments saturate.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (stat_clear) begin
          r_cnt[i] <= '0;
        end else if (w_xfer && (w_grant == TAG_W'(i)) && (r_cnt[i] != '1)) begin
          r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Statistic readout and sticky protocol error.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_stat_count <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      r_stat_count <= (32'(stat_sel) < NREQ) ? r_cnt[stat_sel] : '0;
      r_proto_err  <= r_proto_err | w_err;
    end
  end

  assign stat_count = r_stat_count;
  assign proto_err  = r_proto_err;

endmodule

// File: tb/tb_fifo1_enq_arbiter.sv
// Bench for fifo1_enq_arbiter: three instances (plain RR, BURST=3, 4-bit
// counters) driven by directed phases; a queue/arithmetic model checks every
// cycle and literal tag lists pin the expected sequences.
module tb_fifo1_enq_arbiter;

  logic CLK;
  logic nRST;

  logic [2:0][3:0]   valid;
  logic [2:0][3:0]   fire;
  logic [2:0][3:0]   ena_man;
  logic [2:0]        auto_ena;
  logic [2:0][127:0] dv;
  logic [2:0]        ordy;
  logic [2:0]        clr;
  logic [2:0][1:0]   sel;

  wire  [2:0][3:0]   rdy;
  wire  [2:0]        oena;
  wire  [2:0][31:0]  ov;
  wire  [2:0][1:0]   tag;
  wire  [2:0][15:0]  st;
  wire  [2:0]        perr;

  int n_total = 0;
  int n_bad   = 0;
  int q_tag0[$];
  int q_dat0[$];
  int q_tag1[$];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int unsigned B  = (k == 1) ? 3 : 1;
    localparam int unsigned CW = (k == 2) ? 4 : 16;
    fifo1_enq_arbiter_if #(.NREQ(4), .TAG_W(2), .DATA_WIDTH(32)) bus ();
    logic [CW-1:0] w_st;
    assign bus.req__VALID   = valid[k];
    assign bus.req__ENA     = auto_ena[k] ? (bus.req__RDY & fire[k]) : ena_man[k];
    assign bus.req_v        = dv[k];
    assign bus.out_enq__RDY = ordy[k];
    assign rdy[k]  = bus.req__RDY;
    assign oena[k] = bus.out_enq__ENA;
    assign ov[k]   = bus.out_enq_v;
    assign tag[k]  = bus.out_tag;
    assign st[k]   = 16'(w_st);
    fifo1_enq_arbiter #(
      .NREQ(4), .TAG_W(2), .DATA_WIDTH(32), .BURST(B), .CNT_WIDTH(CW)
    ) u_dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .bus        (bus),
      .stat_clear (clr[k]),
      .stat_sel   (sel[k]),
      .stat_count (w_st),
      .proto_err  (perr[k])
    );
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  int m_ptr   [3] = '{0, 0, 0};
  int m_owner [3] = '{0, 0, 0};
  int m_left  [3] = '{0, 0, 0};
  int m_stat  [3] = '{0, 0, 0};
  int m_err   [3] = '{0, 0, 0};
  int m_cnt   [3][4];

  always @(negedge CLK) begin
    for (int k = 0; k < 3; k++) begin
      int g;
      int bl;
      int mx;
      logic [3:0] er;
      logic [3:0] ee;
      logic ex;
      bl = (k == 1) ? 3 : 1;
      mx = (k == 2) ? 15 : 65535;
      g  = -1;
      if (m_left[k] > 0 && valid[k][m_owner[k]]) g = m_owner[k];
      else begin
        for (int j = 0; j < 4; j++) begin
          if (g < 0 && valid[k][(m_ptr[k] + j) % 4]) g = (m_ptr[k] + j) % 4;
        end
      end
      er = (nRST && ordy[k] && g >= 0) ? 4'(1 << g) : 4'b0000;
      ee = auto_ena[k] ? (er & fire[k]) : ena_man[k];
      ex = |(ee & er);

      chk($sformatf("u%0d_rdy", k),  64'(rdy[k]),  64'(er));
      chk($sformatf("u%0d_ena", k),  64'(oena[k]), 64'(ex));
      chk($sformatf("u%0d_perr", k), 64'(perr[k]), 64'(m_err[k]));
      chk($sformatf("u%0d_stat", k), 64'(st[k]),   64'(m_stat[k]));
      if (!nRST) begin
        chk($sformatf("u%0d_rst_tag", k), 64'(tag[k]), 64'd0);
        chk($sformatf("u%0d_rst_dat", k), 64'(ov[k]),  64'd0);
      end else if (ex) begin
        chk($sformatf("u%0d_tag", k), 64'(tag[k]), 64'(g));
        chk($sformatf("u%0d_dat", k), 64'(ov[k]),  64'(dv[k][g*32 +: 32]));
      end
      if (oena[k] === 1'b1) begin
        if (k == 0) begin
          q_tag0.push_back(int'(tag[0]));
          q_dat0.push_back(int'(ov[0]));
        end
        if (k == 1) q_tag1.push_back(int'(tag[1]));
      end

      // Advance the model to what the next edge must produce.
      if (!nRST) begin
        m_ptr[k] = 0; m_owner[k] = 0; m_left[k] = 0; m_stat[k] = 0; m_err[k] = 0;
        for (int i = 0; i < 4; i++) m_cnt[k][i] = 0;
      end else begin
        if (|(ee & ~er)) m_err[k] = 1;
        m_stat[k] = m_cnt[k][sel[k]];
        if (ordy[k]) begin
          if (m_left[k] > 0 && !valid[k][m_owner[k]]) m_left[k] = 0;
          if (ex) begin
            m_ptr[k] = (g + 1) % 4;
            if (m_cnt[k][g] < mx) m_cnt[k][g] = m_cnt[k][g] + 1;
            if (m_left[k] > 0) m_left[k] = m_left[k] - 1;
            else if (bl > 1) begin
              m_owner[k] = g;
              m_left[k]  = bl - 1;
            end
          end
        end
        if (clr[k]) for (int i = 0; i < 4; i++) m_cnt[k][i] = 0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic rd_stat(input int k, input int s, input int exp, input string nm);
    sel[k] = 2'(s);
    step();
    @(negedge CLK);
    chk(nm, 64'(st[k]), 64'(exp));
  endtask

  task automatic chk_list(input string nm, input int got[$], input int exp[$]);
    chk({nm, "_len"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s[%0d]", nm, i), 64'(got[i]), 64'(exp[i]));
  endtask

  initial begin
    int exp_t0[$];
    int exp_t1[$];
    int exp_d0[$];
    nRST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      valid[k] = 4'hF; fire[k] = 4'hF; ena_man[k] = 4'h0; auto_ena[k] = 1'b1;
      ordy[k] = 1'b1; clr[k] = 1'b0; sel[k] = 2'd0;
      for (int i = 0; i < 4; i++) dv[k][i*32 +: 32] = 32'hA0 + 32'(i);
    end

    // Reset held with every requester valid; sweep stat_sel meanwhile.
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 3; k++) sel[k] = 2'(s);
      @(negedge CLK);
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("rst_rdy%0d_s%0d", k, s),  64'(rdy[k]),  64'd0);
        chk($sformatf("rst_ena%0d_s%0d", k, s),  64'(oena[k]), 64'd0);
        chk($sformatf("rst_stat%0d_s%0d", k, s), 64'(st[k]),   64'd0);
        chk($sformatf("rst_perr%0d_s%0d", k, s), 64'(perr[k]), 64'd0);
      end
      step();
    end
    nRST = 1'b1;
    valid[1] = 4'h0;
    valid[2] = 4'h0;

    // Round-robin: four transfers, one per requester.
    repeat (4) step();
    valid[0] = 4'h0;
    for (int s = 0; s < 4; s++) rd_stat(0, s, 1, $sformatf("rr_cnt%0d", s));
    valid[0] = 4'hF;
    repeat (2) step();
    valid[0] = 4'h0;

    // Leave ptr at 0, then stall the FIFO with VALID=0101.
    valid[0] = 4'b1000;
    step();
    valid[0] = 4'b0101;
    ordy[0]  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk($sformatf("bp_rdy%0d", c), 64'(rdy[0]),  64'd0);
      chk($sformatf("bp_ena%0d", c), 64'(oena[0]), 64'd0);
      step();
    end
    ordy[0] = 1'b1;
    repeat (2) step();
    valid[0] = 4'h0;

    // Requester 2 fires while the grant sits on requester 1.
    valid[0]    = 4'b0110;
    auto_ena[0] = 1'b0;
    ena_man[0]  = 4'b0100;
    @(negedge CLK);
    chk("perr_rdy", 64'(rdy[0]),  64'b0010);
    chk("perr_ena", 64'(oena[0]), 64'd0);
    step();
    valid[0]    = 4'h0;
    ena_man[0]  = 4'h0;
    auto_ena[0] = 1'b1;
    @(negedge CLK);
    chk("perr_set", 64'(perr[0]), 64'd1);
    repeat (10) step();
    @(negedge CLK);
    chk("perr_sticky", 64'(perr[0]), 64'd1);
    rd_stat(0, 2, 2, "perr_cnt2");

    // Transfer from requester 3 coincident with stat_clear.
    valid[0] = 4'b1000;
    clr[0]   = 1'b1;
    step();
    valid[0] = 4'h0;
    clr[0]   = 1'b0;
    rd_stat(0, 3, 0, "clr_cnt3");
    valid[0] = 4'hF;
    step();
    valid[0] = 4'h0;
    rd_stat(0, 0, 1, "clr_cnt0");

    exp_t0 = '{0, 1, 2, 3, 0, 1, 3, 0, 2, 3, 0};
    chk_list("tag0", q_tag0, exp_t0);
    exp_d0 = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    for (int i = 0; i < 4 && i < q_dat0.size(); i++)
      chk($sformatf("dat0[%0d]", i), 64'(q_dat0[i]), 64'(exp_d0[i]));

    // Burst of 3 between requesters 0 and 1, then requester 0 drops mid-burst.
    valid[1] = 4'b0011;
    repeat (8) step();
    valid[1] = 4'b0010;
    step();
    valid[1] = 4'h0;
    step();
    exp_t1 = '{0, 0, 0, 1, 1, 1, 0, 0, 1};
    chk_list("tag1", q_tag1, exp_t1);

    // Saturation of a 4-bit counter.
    valid[2] = 4'b0010;
    repeat (10) step();
    valid[2] = 4'h0;
    rd_stat(2, 1, 10, "sat_cnt10");
    valid[2] = 4'b0010;
    repeat (10) step();
    valid[2] = 4'h0;
    rd_stat(2, 1, 15, "sat_cnt15");
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo1_enq_arbiter.md
Name: fifo1_enq_arbiter

Overview:
- Round-robin arbiter that shares the enq method of a single one-element 32-bit FIFO between NREQ requesters, using ENA/RDY method handshakes.
- Selects one requester per cycle and forwards that requester's data plus a source tag to the FIFO enq port.
- Supports optional burst lock, so one requester can hold the FIFO for up to BURST consecutive transfers.
- Keeps per-requester saturating grant counters for performance statistics, plus a sticky protocol-error flag.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TAG_W, 2, width of the source tag; must satisfy 2**TAG_W >= NREQ.
- DATA_WIDTH, 32, width of enq payload.
- BURST, 1, maximum consecutive transfers granted to one requester (1 = pure round-robin).
- CNT_WIDTH, 16, width of each grant counter.

Ports:
- CLK  input  1  clock
- nRST  input  1  reset, synchronous, active-low
- req__VALID  input  NREQ  bit i: requester i has data to enq
- req__ENA  input  NREQ  bit i: requester i fires enq this cycle
- req_v  input  NREQ*DATA_WIDTH  payloads; slice i = [i*DATA_WIDTH +: DATA_WIDTH]
- req__RDY  output  NREQ  bit i: requester i may fire this cycle (at most one bit high)
- out_enq__RDY  input  1  downstream FIFO enq ready (FIFO not full)
- out_enq__ENA  output  1  enq fire toward the FIFO
- out_enq_v  output  DATA_WIDTH  payload of the granted requester
- out_tag  output  TAG_W  index of the granted requester
- stat_clear  input  1  synchronous clear of all grant counters
- stat_sel  input  TAG_W  selects the counter shown on stat_count
- stat_count  output  CNT_WIDTH  grant count of requester stat_sel
- proto_err  output  1  sticky: some req__ENA bit was high while its req__RDY bit was low

Behaviour:
- Reset (nRST low at posedge):
  - ptr=0, state=ARB, owner=0, bcnt=0, all counters=0, proto_err=0.
  - While nRST is low: req__RDY=0, out_enq__ENA=0, out_tag=0, out_enq_v=0.
  - Reset asserted mid-burst abandons the burst; no transfer is counted in that cycle.
- Grant (combinational, from registered state):
  - HOLD state with req__VALID[owner]=1: grant=owner.
  - Otherwise: grant = first i with req__VALID[i]=1, scanning ptr, ptr+1, ... modulo NREQ.
  - No VALID bit set: no grant.
- req__RDY[i] = nRST & out_enq__RDY & any-VALID & (grant==i).
  - RDY never depends on req__ENA.
- Transfer: xfer = |(req__ENA & req__RDY).
  - out_enq__ENA = xfer.
  - out_enq_v = req_v slice[grant]; out_tag = grant.
  - Zero added latency: the FIFO captures the data on the same edge.
- Transfer with grant g:
  - ptr <= (g==NREQ-1) ? 0 : g+1.
  - counter[g] increments, saturating at all-ones.
- State machine (ARB, HOLD):
  - ARB -> HOLD on a transfer when BURST>1; owner<=g, bcnt<=1.
  - HOLD, on a transfer: bcnt<=bcnt+1. If bcnt+1==BURST, go to ARB and set bcnt<=0.
  - HOLD with req__VALID[owner]=0: go to ARB with bcnt<=0. The grant in this cycle is already round-robin from ptr, so no idle bubble.
  - HOLD with out_enq__RDY=0: stay in HOLD; bcnt holds.
  - BURST=1: the state stays ARB permanently.
- out_enq__RDY=0 (FIFO full): all req__RDY=0; ptr, state, bcnt and counters hold.
- Protocol error: any i with req__ENA[i]=1 and req__RDY[i]=0.
  - That ENA is ignored: no transfer, no state change.
  - proto_err <= 1 and stays set until reset.
- stat_clear:
  - All counters go to 0 on the next edge.
  - stat_clear wins over a simultaneous transfer; that transfer is not counted, but the FIFO still receives it and ptr/state still update.
- stat_count is the registered counter[stat_sel]; a stat_sel >= NREQ reads 0.

Test Plan:
- Reset: hold nRST=0 for 2 cycles with all VALID=1 and out_enq__RDY=1 -> req__RDY=0000, out_enq__ENA=0, stat_count=0 for every stat_sel, proto_err=0.
- Round-robin (BURST=1): VALID=1111, every requester fires whenever RDY, payload i = 0xA0+i, FIFO always ready -> out_tag sequence 0,1,2,3,0,1; out_enq_v 0xA0,0xA1,0xA2,0xA3; each counter reads 1 after 4 transfers.
- Back-pressure: VALID=0101, out_enq__RDY low for 3 cycles then high -> req__RDY=0000 while low; first grant afterward is requester 0, then requester 2; ptr unchanged while stalled.
- Burst (BURST=3): VALID=0011 with both firing continuously -> tags 0,0,0,1,1,1,0. With VALID[0] dropped after its 2nd transfer, the next tag is 1 in the immediately following cycle.
- Protocol error: drive req__ENA[2]=1 while RDY points to requester 1 -> out_enq__ENA=0, proto_err=1 next cycle and still set after 10 cycles, counter[2] unchanged.
- Counters: transfer on requester 3 in the same cycle as stat_clear=1 -> stat_count[3]=0 afterward and ptr=0. With CNT_WIDTH=4, 20 transfers from requester 1 -> stat_count saturates at 15.
